// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, next-PC select encoding and the opcodes
// the front end has to recognise.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,
    PC_BR  = 2'b01,
    PC_J   = 2'b10,
    PC_JR  = 2'b11
  } pcsrc_t;

  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] BNE  = 6'b000101;
  localparam logic [5:0] J    = 6'b000010;
  localparam logic [5:0] JAL  = 6'b000011;
  localparam logic [5:0] HALT = 6'b111111;

  // Branch displacement is a signed word offset relative to PC+4.
  function automatic word_t branch_target(input word_t pc4, input logic [15:0] imm);
    return pc4 + {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/if_id_latch.sv
// IF/ID pipeline register. Stall (wen=0) beats flush, flush beats a fetch,
// and a cycle without ihit leaves a bubble behind.
module if_id_latch
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  i_wen,
  input  logic  i_flush,
  input  logic  i_ihit,
  input  word_t i_instr,
  input  word_t i_pc4,
  output word_t o_instr,
  output word_t o_pc4,
  output logic  o_valid,
  output logic  o_load
);

  word_t r_instr;
  word_t r_pc4;
  logic  r_valid;

  assign o_load = i_wen && !i_flush && i_ihit;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_instr <= '0;
      r_pc4   <= '0;
      r_valid <= 1'b0;
    end else if (i_wen) begin
      if (o_load) begin
        r_instr <= i_instr;
        r_pc4   <= i_pc4;
        r_valid <= 1'b1;
      end else begin
        r_instr <= '0;
        r_pc4   <= '0;
        r_valid <= 1'b0;
      end
    end
  end

  assign o_instr = r_instr;
  assign o_pc4   = r_pc4;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, next-PC selection, sticky halt and the IF/ID latch.
// Redirect targets are resolved from the PC+4 held in IF/ID.
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter word_t      PC_INIT = 32'h00000000,
  parameter logic [5:0] HALT_OP = 6'b111111
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  word_t       imemload,
  input  logic        pc_wen,
  input  logic        if_id_wen,
  input  logic        if_id_flush,
  input  logic [1:0]  pc_src,
  input  logic [15:0] branch_imm,
  input  logic [25:0] jump_addr,
  input  word_t       jr_addr,
  output word_t       imemaddr,
  output logic        imemREN,
  output word_t       if_id_instr,
  output word_t       if_id_pc4,
  output logic        if_id_valid,
  output logic [4:0]  id_rs,
  output logic [4:0]  id_rt,
  output logic        halt_fetched
);

  word_t r_pc;
  logic  r_halt;
  word_t w_pc4;
  word_t w_next_pc;
  word_t w_if_id_instr;
  word_t w_if_id_pc4;
  logic  w_load;

  assign w_pc4 = r_pc + 32'd4;

  // NOTE: the default assignment ahead of the case keeps this block purely
  // combinational; without it a missed arm would infer a latch.
  always_comb begin
    w_next_pc = w_pc4;
    case (pcsrc_t'(pc_src))
      PC_SEQ: w_next_pc = w_pc4;
      PC_BR:  w_next_pc = branch_target(w_if_id_pc4, branch_imm);
      PC_J:   w_next_pc = {w_if_id_pc4[31:28], jump_addr, 2'b00};
      PC_JR:  w_next_pc = jr_addr;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_pc <= PC_INIT;
    end else if (pc_wen && !r_halt) begin
      r_pc <= w_next_pc;
    end
  end

  // Halt is raised only by an instruction actually entering IF/ID.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_halt <= 1'b0;
    end else if (w_load && (imemload[31:26] == HALT_OP)) begin
      r_halt <= 1'b1;
    end
  end

  if_id_latch u_if_id_latch (
    .CLK     (CLK),
    .nRST    (nRST),
    .i_wen   (if_id_wen),
    .i_flush (if_id_flush),
    .i_ihit  (ihit),
    .i_instr (imemload),
    .i_pc4   (w_pc4),
    .o_instr (w_if_id_instr),
    .o_pc4   (w_if_id_pc4),
    .o_valid (if_id_valid),
    .o_load  (w_load)
  );

  assign imemaddr     = r_pc;
  assign imemREN      = ~r_halt;
  assign if_id_instr  = w_if_id_instr;
  assign if_id_pc4    = w_if_id_pc4;
  assign id_rs        = w_if_id_instr[25:21];
  assign id_rt        = w_if_id_instr[20:16];
  assign halt_fetched = r_halt;

endmodule
